grad_scan_ctrl: RTL

- Raster-scan sequencer for the gradient magnitude/direction unit in the edge-detection pipeline.
- On `start`, walks every pixel address of one frame and issues reads to the dx/dy source buffer.
- Drives the gradient unit's clock enable and tracks the read + unit pipeline latency.
- Emits write strobes, addresses and a border flag to the result writer; supports writer backpressure and signals frame completion.

---
 rtl/grad_scan_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/grad_scan_ctrl.sv
// Raster-scan sequencer for the gradient unit: issues one source read per enabled
// cycle, tracks the read + unit latency and hands address/border to the result writer.
module grad_scan_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              unit_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_border
);
  // Issue-to-write delay is 1 (buffer read) + LAT, so the tail sits at index LAT.
  localparam int STAGES = LAT;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              border;
  } pix_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] lin;
  logic [STAGES:0]   vld_pipe;
  pix_t [STAGES:0]   pix_pipe;

  logic issue, border, last_pix, pipe_drained;

  assign issue    = (state == S_RUN) & out_ready;
  assign border   = (col == '0) | (col == COL_LAST) | (row == '0) | (row == ROW_LAST);
  assign last_pix = (lin == ADDR_LAST);
  // True when no valid entry will remain after this edge (tail leaves only if written).
  assign pipe_drained = out_ready ? ~|vld_pipe[STAGES-1:0] : ~|vld_pipe;

  assign rd_en     = issue;
  assign rd_addr   = lin;
  assign unit_en   = out_ready;
  assign wr_en     = vld_pipe[STAGES] & out_ready;
  assign wr_addr   = pix_pipe[STAGES].addr;
  assign wr_border = pix_pipe[STAGES].border;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      lin   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          busy  <= 1'b1;
          col   <= '0;
          row   <= '0;
          lin   <= '0;
        end
        S_RUN: if (out_ready) begin
          // Counters park on the last pixel so rd_addr never wraps past the frame.
          if (last_pix) begin
            state <= S_DRAIN;
          end else begin
            lin <= lin + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: if (pipe_drained) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Whole pipeline freezes with the writer; bubbles carry zeroed payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      pix_pipe <= '0;
    end else if (out_ready) begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], issue};
      pix_pipe[0] <= issue ? pix_t'{addr: lin, border: border} : pix_t'('0);
      for (int i = 1; i <= STAGES; i++) pix_pipe[i] <= pix_pipe[i-1];
    end
  end

endmodule
